vga_io_regs: RTL and testbench

//  CPU-side I/O register file for the video adapter: DAC palette (3C7/3C8/3C9),

---
 rtl/vga_io_regs.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_vga_io_regs.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_io_regs.sv
// vga_io_regs -- CPU-side I/O register file for the video adapter.
//   DAC palette ports 3C7/3C8/3C9, CRTC cursor registers via 3D4/3D5,
//   mode register 3D8. Feeds the display stage with cursor position,
//   cursor shape and video mode, and answers its palette lookups with
//   {8'h00, R8, G8, B8} one cycle after the index is presented.
// Optional feature macro: PALETTE_INIT_EN -- when defined, a small FSM loads
//   the CGA 16-colour set into entries 0..15 (and black into 16..255) after
//   every reset, holding busy high for the 256 cycles this takes.
module vga_io_regs #(
   parameter int         DAC_DEPTH    = 256,
   parameter logic [5:0] SHAPE_LO_RST = 6'd14,
   parameter logic [4:0] SHAPE_HI_RST = 5'd15
) (
   input  logic        clock_25,
   input  logic        reset,
   input  logic [15:0] port_address,
   input  logic [7:0]  port_in,
   input  logic        port_write,
   input  logic        port_read,
   output logic [7:0]  port_out,
   output logic        busy,
   input  logic [7:0]  vga_dac_address,
   output logic [31:0] vga_dac_data,
   output logic [10:0] cursor,
   output logic [5:0]  cursor_shape_lo,
   output logic [4:0]  cursor_shape_hi,
   output logic [1:0]  videomode
);

   // I/O port map
   localparam logic [15:0] ADDR_DAC_RD_IDX = 16'h03C7;
   localparam logic [15:0] ADDR_DAC_WR_IDX = 16'h03C8;
   localparam logic [15:0] ADDR_DAC_DATA   = 16'h03C9;
   localparam logic [15:0] ADDR_CRTC_IDX   = 16'h03D4;
   localparam logic [15:0] ADDR_CRTC_DATA  = 16'h03D5;
   localparam logic [15:0] ADDR_MODE       = 16'h03D8;

   // CRTC register indices that are implemented
   localparam logic [4:0] CRTC_SHAPE_LO = 5'h0A;
   localparam logic [4:0] CRTC_SHAPE_HI = 5'h0B;
   localparam logic [4:0] CRTC_CUR_HI   = 5'h0E;
   localparam logic [4:0] CRTC_CUR_LO   = 5'h0F;

   // DAC triplet phase encoding (shared by the read and write sequencers)
   localparam logic [1:0] PH_R = 2'd0;
   localparam logic [1:0] PH_G = 2'd1;
   localparam logic [1:0] PH_B = 2'd2;

   // Expand a 6-bit DAC component to 8 bits by replicating its top bits,
   // so 3F maps to FF and 00 stays 00.
   function automatic logic [7:0] x8(input logic [5:0] v);
      return {v, v[5:4]};
   endfunction

   // Next phase in the R -> G -> B -> R cycle; an unused code recovers to R.
   function automatic logic [1:0] next_phase(input logic [1:0] ph);
      logic [1:0] nxt;
      case (ph)
         PH_R:    nxt = PH_G;
         PH_G:    nxt = PH_B;
         default: nxt = PH_R;
      endcase
      return nxt;
   endfunction

`ifdef PALETTE_INIT_EN
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_INIT = 1'b1;

   // Default palette: CGA 16-colour set in 0..15, black everywhere else.
   function automatic logic [23:0] cga_colour(input logic [7:0] idx);
      logic [23:0] rgb;
      if (idx[7:4] != 4'h0) begin
         rgb = 24'h000000;
      end else begin
         case (idx[3:0])
            4'd0:    rgb = 24'h000000;
            4'd1:    rgb = 24'h0000AA;
            4'd2:    rgb = 24'h00AA00;
            4'd3:    rgb = 24'h00AAAA;
            4'd4:    rgb = 24'hAA0000;
            4'd5:    rgb = 24'hAA00AA;
            4'd6:    rgb = 24'hAA5500;
            4'd7:    rgb = 24'hAAAAAA;
            4'd8:    rgb = 24'h555555;
            4'd9:    rgb = 24'h5555FF;
            4'd10:   rgb = 24'h55FF55;
            4'd11:   rgb = 24'h55FFFF;
            4'd12:   rgb = 24'hFF5555;
            4'd13:   rgb = 24'hFF55FF;
            4'd14:   rgb = 24'hFFFF55;
            default: rgb = 24'hFFFFFF;
         endcase
      end
      return rgb;
   endfunction

   logic [0:0] state_q, state_d;
   logic [7:0] init_idx_q, init_idx_d;
`endif

   // Register state
   logic [7:0]  port_out_q, port_out_d;
   logic [10:0] cursor_q, cursor_d;
   logic [5:0]  shape_lo_q, shape_lo_d;
   logic [4:0]  shape_hi_q, shape_hi_d;
   logic [1:0]  videomode_q, videomode_d;
   logic [4:0]  crtc_index_q, crtc_index_d;
   logic [7:0]  dac_wr_idx_q, dac_wr_idx_d;
   logic [7:0]  dac_rd_idx_q, dac_rd_idx_d;
   logic [1:0]  wr_phase_q, wr_phase_d;
   logic [1:0]  rd_phase_q, rd_phase_d;
   logic [5:0]  lat_r_q, lat_r_d;
   logic [5:0]  lat_g_q, lat_g_d;
   logic [31:0] vga_dac_data_q, vga_dac_data_d;

   // Palette storage (24-bit RGB per entry) and its single write port
   logic [23:0] pal_q [0:DAC_DEPTH-1];
   logic        pal_we_d;
   logic [7:0]  pal_waddr_d;
   logic [23:0] pal_wdata_d;

   logic        busy_s;
   logic [23:0] pal_rd_entry_s;
   logic [7:0]  rd_comp_s;
   logic [7:0]  crtc_rd_s;

`ifdef PALETTE_INIT_EN
   assign busy_s = (state_q == ST_INIT);
`else
   assign busy_s = 1'b0;
`endif

   // Select the colour component the CPU read sequencer is pointing at
   always_comb begin
      pal_rd_entry_s = pal_q[dac_rd_idx_q];
      case (rd_phase_q)
         PH_R:    rd_comp_s = pal_rd_entry_s[23:16];
         PH_G:    rd_comp_s = pal_rd_entry_s[15:8];
         default: rd_comp_s = pal_rd_entry_s[7:0];
      endcase
   end

   // Read-back value of the CRTC data port for the current index
   always_comb begin
      case (crtc_index_q)
         CRTC_SHAPE_LO: crtc_rd_s = {2'b00, shape_lo_q};
         CRTC_SHAPE_HI: crtc_rd_s = {3'b000, shape_hi_q};
         CRTC_CUR_HI:   crtc_rd_s = {5'b00000, cursor_q[10:8]};
         CRTC_CUR_LO:   crtc_rd_s = cursor_q[7:0];
         default:       crtc_rd_s = 8'hFF;
      endcase
   end

   // Next-state logic: CPU port decode, DAC sequencers and palette init
   always_comb begin
      port_out_d     = port_out_q;
      cursor_d       = cursor_q;
      shape_lo_d     = shape_lo_q;
      shape_hi_d     = shape_hi_q;
      videomode_d    = videomode_q;
      crtc_index_d   = crtc_index_q;
      dac_wr_idx_d   = dac_wr_idx_q;
      dac_rd_idx_d   = dac_rd_idx_q;
      wr_phase_d     = wr_phase_q;
      rd_phase_d     = rd_phase_q;
      lat_r_d        = lat_r_q;
      lat_g_d        = lat_g_q;
      pal_we_d       = 1'b0;
      pal_waddr_d    = dac_wr_idx_q;
      pal_wdata_d    = {x8(lat_r_q), x8(lat_g_q), x8(port_in[5:0])};
      // Display lookup: reads the array before this cycle's write lands
      vga_dac_data_d = {8'h00, pal_q[vga_dac_address]};

      // A write wins over a simultaneous read; port_out then holds.
      if (port_write) begin
         case (port_address)
            ADDR_DAC_WR_IDX: begin
               dac_wr_idx_d = port_in;
               wr_phase_d   = PH_R;
            end
            ADDR_DAC_RD_IDX: begin
               dac_rd_idx_d = port_in;
               rd_phase_d   = PH_R;
            end
            ADDR_DAC_DATA: begin
               // Palette is owned by the init walk while busy
               if (!busy_s) begin
                  case (wr_phase_q)
                     PH_R: begin
                        lat_r_d    = port_in[5:0];
                        wr_phase_d = PH_G;
                     end
                     PH_G: begin
                        lat_g_d    = port_in[5:0];
                        wr_phase_d = PH_B;
                     end
                     default: begin
                        pal_we_d     = 1'b1;
                        dac_wr_idx_d = dac_wr_idx_q + 8'd1;
                        wr_phase_d   = PH_R;
                     end
                  endcase
               end else begin
                  wr_phase_d = wr_phase_q;
               end
            end
            ADDR_CRTC_IDX: begin
               crtc_index_d = port_in[4:0];
            end
            ADDR_CRTC_DATA: begin
               case (crtc_index_q)
                  CRTC_SHAPE_LO: shape_lo_d = port_in[5:0];
                  CRTC_SHAPE_HI: shape_hi_d = port_in[4:0];
                  CRTC_CUR_HI:   cursor_d   = {port_in[2:0], cursor_q[7:0]};
                  CRTC_CUR_LO:   cursor_d   = {cursor_q[10:8], port_in};
                  default:       cursor_d   = cursor_q;
               endcase
            end
            ADDR_MODE: begin
               videomode_d = port_in[1:0];
            end
            default: begin
               port_out_d = port_out_q;
            end
         endcase
      end else if (port_read) begin
         case (port_address)
            ADDR_DAC_RD_IDX: begin
               port_out_d = (rd_phase_q == PH_R) ? 8'h00 : 8'h03;
            end
            ADDR_DAC_WR_IDX: begin
               port_out_d = dac_wr_idx_q;
            end
            ADDR_DAC_DATA: begin
               port_out_d = {2'b00, rd_comp_s[7:2]};
               rd_phase_d = next_phase(rd_phase_q);
               if (rd_phase_q == PH_B) begin
                  dac_rd_idx_d = dac_rd_idx_q + 8'd1;
               end else begin
                  dac_rd_idx_d = dac_rd_idx_q;
               end
            end
            ADDR_CRTC_IDX: begin
               port_out_d = {3'b000, crtc_index_q};
            end
            ADDR_CRTC_DATA: begin
               port_out_d = crtc_rd_s;
            end
            ADDR_MODE: begin
               port_out_d = {6'b000000, videomode_q};
            end
            default: begin
               port_out_d = 8'hFF;
            end
         endcase
      end else begin
         port_out_d = port_out_q;
      end

`ifdef PALETTE_INIT_EN
      state_d    = state_q;
      init_idx_d = init_idx_q;
      case (state_q)
         ST_INIT: begin
            pal_we_d    = 1'b1;
            pal_waddr_d = init_idx_q;
            pal_wdata_d = cga_colour(init_idx_q);
            init_idx_d  = init_idx_q + 8'd1;
            if (init_idx_q == 8'hFF) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_INIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
`endif
   end

   // Register update with synchronous reset; palette is not touched here
   always_ff @(posedge clock_25) begin
      if (reset) begin
         port_out_q     <= 8'hFF;
         cursor_q       <= 11'd0;
         shape_lo_q     <= SHAPE_LO_RST;
         shape_hi_q     <= SHAPE_HI_RST;
         videomode_q    <= 2'd0;
         crtc_index_q   <= 5'd0;
         dac_wr_idx_q   <= 8'd0;
         dac_rd_idx_q   <= 8'd0;
         wr_phase_q     <= PH_R;
         rd_phase_q     <= PH_R;
         lat_r_q        <= 6'd0;
         lat_g_q        <= 6'd0;
         vga_dac_data_q <= 32'd0;
      end else begin
         port_out_q     <= port_out_d;
         cursor_q       <= cursor_d;
         shape_lo_q     <= shape_lo_d;
         shape_hi_q     <= shape_hi_d;
         videomode_q    <= videomode_d;
         crtc_index_q   <= crtc_index_d;
         dac_wr_idx_q   <= dac_wr_idx_d;
         dac_rd_idx_q   <= dac_rd_idx_d;
         wr_phase_q     <= wr_phase_d;
         rd_phase_q     <= rd_phase_d;
         lat_r_q        <= lat_r_d;
         lat_g_q        <= lat_g_d;
         vga_dac_data_q <= vga_dac_data_d;
      end
   end

`ifdef PALETTE_INIT_EN
   // Init FSM: reset (re)starts the walk at entry 0
   always_ff @(posedge clock_25) begin
      if (reset) begin
         state_q    <= ST_INIT;
         init_idx_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
      end
   end
`endif

   // Palette write port; the write is suppressed while reset is asserted
   // so an interrupted triplet can never commit
   always_ff @(posedge clock_25) begin
      if (pal_we_d && !reset) begin
         pal_q[pal_waddr_d] <= pal_wdata_d;
      end
   end

   assign port_out        = port_out_q;
   assign busy            = busy_s;
   assign vga_dac_data    = vga_dac_data_q;
   assign cursor          = cursor_q;
   assign cursor_shape_lo = shape_lo_q;
   assign cursor_shape_hi = shape_hi_q;
   assign videomode       = videomode_q;

endmodule

// File: tb/tb_vga_io_regs.sv
// Testbench for vga_io_regs: directed steps plus a randomized CPU I/O
// sequence, checked against a port-level behavioural model of the register
// file and palette.
module tb_vga_io_regs;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] port_address = 16'h0000;
   logic [7:0]  port_in = 8'h00;
   logic        port_write = 1'b0;
   logic        port_read = 1'b0;
   logic [7:0]  port_out;
   logic        busy;
   logic [7:0]  vga_dac_address = 8'h00;
   logic [31:0] vga_dac_data;
   logic [10:0] cursor;
   logic [5:0]  cursor_shape_lo;
   logic [4:0]  cursor_shape_hi;
   logic [1:0]  videomode;

   int n_tests = 0;
   int n_fail  = 0;

   always #20 clk = ~clk;

   vga_io_regs dut (
      .clock_25        (clk),
      .reset           (reset),
      .port_address    (port_address),
      .port_in         (port_in),
      .port_write      (port_write),
      .port_read       (port_read),
      .port_out        (port_out),
      .busy            (busy),
      .vga_dac_address (vga_dac_address),
      .vga_dac_data    (vga_dac_data),
      .cursor          (cursor),
      .cursor_shape_lo (cursor_shape_lo),
      .cursor_shape_hi (cursor_shape_hi),
      .videomode       (videomode)
   );

   // ---------------- reference model ----------------
   logic [23:0] m_pal [256];
   int          m_wr_idx, m_rd_idx;   // 0..255
   int          m_wr_ph, m_rd_ph;     // 0=R 1=G 2=B
   int          m_lat_r, m_lat_g;     // 6-bit values
   int          m_crtc;
   int          m_cursor, m_slo, m_shi, m_vm;
   logic [7:0]  m_pout;

   // 6-bit DAC value scaled to 8 bits: v*4 plus its top two bits
   function automatic logic [7:0] ex8(input int v);
      int w;
      w = v % 64;
      return 8'((w * 4) + (w / 16));
   endfunction

   function automatic logic [23:0] cga(input int i);
      logic [23:0] t [16];
      t = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
            24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
            24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
            24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
      return (i < 16) ? t[i] : 24'h000000;
   endfunction

   task automatic m_reset();
      m_wr_idx = 0; m_rd_idx = 0; m_wr_ph = 0; m_rd_ph = 0;
      m_lat_r = 0; m_lat_g = 0; m_crtc = 0; m_cursor = 0;
      m_slo = 14; m_shi = 15; m_vm = 0; m_pout = 8'hFF;
   endtask

   task automatic m_write(input logic [15:0] a, input int d);
      case (a)
         16'h03C8: begin m_wr_idx = d; m_wr_ph = 0; end
         16'h03C7: begin m_rd_idx = d; m_rd_ph = 0; end
         16'h03C9: begin
            if (m_wr_ph == 0) begin m_lat_r = d % 64; m_wr_ph = 1; end
            else if (m_wr_ph == 1) begin m_lat_g = d % 64; m_wr_ph = 2; end
            else begin
               m_pal[m_wr_idx] = {ex8(m_lat_r), ex8(m_lat_g), ex8(d)};
               m_wr_idx = (m_wr_idx + 1) % 256;
               m_wr_ph = 0;
            end
         end
         16'h03D4: m_crtc = d % 32;
         16'h03D5: begin
            if (m_crtc == 10) m_slo = d % 64;
            else if (m_crtc == 11) m_shi = d % 32;
            else if (m_crtc == 14) m_cursor = (d % 8) * 256 + (m_cursor % 256);
            else if (m_crtc == 15) m_cursor = (m_cursor / 256) * 256 + d;
         end
         16'h03D8: m_vm = d % 4;
         default: ;
      endcase
   endtask

   task automatic m_read(input logic [15:0] a, output logic [7:0] e);
      logic [23:0] ent;
      int comp;
      case (a)
         16'h03C7: e = (m_rd_ph == 0) ? 8'h00 : 8'h03;
         16'h03C8: e = 8'(m_wr_idx);
         16'h03C9: begin
            ent  = m_pal[m_rd_idx];
            comp = (m_rd_ph == 0) ? int'(ent[23:16]) :
                   (m_rd_ph == 1) ? int'(ent[15:8]) : int'(ent[7:0]);
            e = 8'(comp / 4);
            m_rd_ph = m_rd_ph + 1;
            if (m_rd_ph == 3) begin m_rd_ph = 0; m_rd_idx = (m_rd_idx + 1) % 256; end
         end
         16'h03D4: e = 8'(m_crtc);
         16'h03D5: begin
            if (m_crtc == 10) e = 8'(m_slo);
            else if (m_crtc == 11) e = 8'(m_shi);
            else if (m_crtc == 14) e = 8'(m_cursor / 256);
            else if (m_crtc == 15) e = 8'(m_cursor % 256);
            else e = 8'hFF;
         end
         16'h03D8: e = 8'(m_vm);
         default: e = 8'hFF;
      endcase
      m_pout = e;
   endtask

   // ---------------- bus helpers (entered/left #1 after posedge) ----------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic io_write(input logic [15:0] a, input logic [7:0] d);
      port_address = a; port_in = d; port_write = 1'b1;
      @(posedge clk); #1;
      port_write = 1'b0;
      m_write(a, int'(d));
   endtask

   task automatic io_read(input logic [15:0] a, output logic [7:0] d);
      port_address = a; port_read = 1'b1;
      @(posedge clk); #1;
      port_read = 1'b0;
      d = port_out;
   endtask

   task automatic read_chk(input string tag, input logic [15:0] a);
      logic [7:0] got, e;
      io_read(a, got);
      m_read(a, e);
      chk(tag, {24'h0, got}, {24'h0, e});
   endtask

   task automatic lookup_chk(input string tag, input logic [7:0] idx);
      vga_dac_address = idx;
      @(posedge clk); #1;
      chk(tag, vga_dac_data, {8'h00, m_pal[idx]});
   endtask

   task automatic outs_chk(input string tag);
      chk({tag, "_cursor"}, {21'h0, cursor}, 32'(m_cursor));
      chk({tag, "_slo"}, {26'h0, cursor_shape_lo}, 32'(m_slo));
      chk({tag, "_shi"}, {27'h0, cursor_shape_hi}, 32'(m_shi));
      chk({tag, "_vm"}, {30'h0, videomode}, 32'(m_vm));
   endtask

   task automatic do_reset(input int cycles);
      int n;
      reset = 1'b1; port_write = 1'b0; port_read = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      reset = 1'b0;
      m_reset();
`ifdef PALETTE_INIT_EN
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("init_busy_cycles", 32'(n), 32'd256);
      for (int i = 0; i < 256; i++) m_pal[i] = cga(i);
`else
      n = 0;
      chk("busy_tied_low", {31'h0, busy}, 32'd0);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  d, got;
      logic [15:0] a;
      logic [15:0] unmapped [4];
      logic [4:0]  crtc_pick [4];
      int          op;
      unmapped  = '{16'h03C6, 16'h03DA, 16'h0060, 16'h03D9};
      crtc_pick = '{5'h0A, 5'h0B, 5'h0E, 5'h0F};
      for (int i = 0; i < 256; i++) m_pal[i] = 24'h000000;

      // Reset values
      do_reset(3);
      chk("rst_port_out", {24'h0, port_out}, 32'h0000_00FF);
      outs_chk("rst");

      // Single palette entry write and display lookup
      io_write(16'h03C8, 8'h05);
      io_write(16'h03C9, 8'h3F);
      io_write(16'h03C9, 8'h20);
      io_write(16'h03C9, 8'h00);
      read_chk("wr_idx_after_triplet", 16'h03C8);
      vga_dac_address = 8'h05;
      @(posedge clk); #1;
      chk("lookup_pal5", vga_dac_data, 32'h00FF_8200);

      // Fill the whole palette with random data (top bits random too)
      io_write(16'h03C8, 8'h00);
      for (int i = 0; i < 768; i++) io_write(16'h03C9, 8'($urandom));
      read_chk("wr_idx_after_fill", 16'h03C8);
      for (int i = 0; i < 6; i++) lookup_chk("lookup_fill", 8'($urandom));

      // Index wrap FF -> 00
      io_write(16'h03C8, 8'hFF);
      for (int i = 0; i < 6; i++) io_write(16'h03C9, 8'($urandom));
      lookup_chk("wrap_entry_ff", 8'hFF);
      lookup_chk("wrap_entry_00", 8'h00);
      read_chk("wrap_wr_idx", 16'h03C8);

      // Directed palette readback, including advance into the next entry
      io_write(16'h03C8, 8'h05);
      io_write(16'h03C9, 8'h3F);
      io_write(16'h03C9, 8'h20);
      io_write(16'h03C9, 8'h00);
      io_write(16'h03C7, 8'h05);
      read_chk("rd_phase_r", 16'h03C7);
      read_chk("rd_pal5_r", 16'h03C9);
      chk("rd_pal5_r_const", {24'h0, port_out}, 32'h0000_003F);
      read_chk("rd_phase_nonr", 16'h03C7);
      read_chk("rd_pal5_g", 16'h03C9);
      chk("rd_pal5_g_const", {24'h0, port_out}, 32'h0000_0020);
      read_chk("rd_pal5_b", 16'h03C9);
      read_chk("rd_pal6_r", 16'h03C9);

      // Cursor and shape registers
      io_write(16'h03D4, 8'h0E);
      io_write(16'h03D5, 8'h07);
      io_write(16'h03D4, 8'h0F);
      io_write(16'h03D5, 8'hCF);
      chk("cursor_7cf", {21'h0, cursor}, 32'h0000_07CF);
      io_write(16'h03D4, 8'h0A);
      io_write(16'h03D5, 8'h06);
      chk("shape_lo_6", {26'h0, cursor_shape_lo}, 32'd6);
      read_chk("crtc_idx_read", 16'h03D4);
      io_write(16'h03D4, 8'h03);
      io_write(16'h03D5, 8'h55);
      read_chk("crtc_unimpl_read", 16'h03D5);
      outs_chk("crtc_dir");

      // Simultaneous write and read: write lands, port_out holds
      read_chk("pre_same_cycle", 16'h03D8);
      port_address = 16'h03D8; port_in = 8'h02; port_write = 1'b1; port_read = 1'b1;
      @(posedge clk); #1;
      port_write = 1'b0; port_read = 1'b0;
      m_write(16'h03D8, 32'd2);
      chk("same_cycle_hold", {24'h0, port_out}, {24'h0, m_pout});
      outs_chk("same_cycle");

      // Display read of an entry being committed returns the old data
      io_write(16'h03C8, 8'h40);
      io_write(16'h03C9, 8'($urandom));
      io_write(16'h03C9, 8'($urandom));
      vga_dac_address = 8'h40;
      d = 8'($urandom);
      port_address = 16'h03C9; port_in = d; port_write = 1'b1;
      @(posedge clk); #1;
      port_write = 1'b0;
      chk("rbw_old_data", vga_dac_data, {8'h00, m_pal[64]});
      m_write(16'h03C9, int'(d));
      @(posedge clk); #1;
      chk("rbw_new_data", vga_dac_data, {8'h00, m_pal[64]});

      // Randomized mixed traffic
      for (int i = 0; i < 300; i++) begin
         op = int'($urandom_range(0, 12));
         d  = 8'($urandom);
         case (op)
            0: io_write(16'h03C8, d);
            1: io_write(16'h03C7, d);
            2, 3: io_write(16'h03C9, d);
            4, 5: read_chk("rnd_3c9", 16'h03C9);
            6: read_chk("rnd_3c7_3c8", ($urandom_range(0, 1) == 0) ? 16'h03C7 : 16'h03C8);
            7: io_write(16'h03D4, ($urandom_range(0, 3) != 0) ?
                        {3'b000, crtc_pick[$urandom_range(0, 3)]} : d);
            8: begin io_write(16'h03D5, d); outs_chk("rnd_crtc"); end
            9: read_chk("rnd_crtc_rd", ($urandom_range(0, 1) == 0) ? 16'h03D5 : 16'h03D4);
            10: begin io_write(16'h03D8, d); outs_chk("rnd_mode"); read_chk("rnd_mode_rd", 16'h03D8); end
            11: begin a = unmapped[$urandom_range(0, 3)]; read_chk("rnd_unmapped", a);
                      io_write(a, d); end
            default: lookup_chk("rnd_lookup", 8'($urandom));
         endcase
      end
      outs_chk("rnd_end");

      // Reset in the middle of a triplet commits nothing
      io_write(16'h03C8, 8'h10);
      io_write(16'h03C9, 8'h3F);
      io_write(16'h03C9, 8'h3F);
      do_reset(2);
      chk("mid_rst_port_out", {24'h0, port_out}, 32'h0000_00FF);
      outs_chk("mid_rst");
      read_chk("mid_rst_wr_idx", 16'h03C8);
      read_chk("mid_rst_rd_phase", 16'h03C7);
      lookup_chk("mid_rst_entry10", 8'h10);
      io_write(16'h03C9, 8'h01);
      io_write(16'h03C9, 8'h02);
      io_write(16'h03C9, 8'h03);
      lookup_chk("post_rst_entry00", 8'h00);
      lookup_chk("post_rst_entry10", 8'h10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
